sprite_rom_arbiter: RTL

//   Shares one registered sprite-mask ROM (dot, big_dot, pacman f1/f2, ghost f1/f2,

---
 rtl/sprite_rom_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one registered sprite-mask ROM among N_REQ renderers.
// One row read per grant; the row is returned with a one-cycle rsp_valid pulse.
module sprite_rom_arbiter #(
  parameter int N_REQ     = 4,
  parameter int TILE_SIZE = 16,
  parameter int N_SPRITES = 14,
  parameter int ROM_LAT   = 1,
  localparam int SW = 4,
  localparam int RW = $clog2(TILE_SIZE),
  localparam int IW = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*SW-1:0]    req_sprite,
  input  logic [N_REQ*RW-1:0]    req_row,
  output logic                   rom_en,
  output logic [SW+RW-1:0]       rom_addr,
  input  logic [TILE_SIZE-1:0]   rom_data,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [TILE_SIZE-1:0]   rsp_data,
  output logic                   busy,
  output logic [1:0]             fsm_state
);

  // Handshake: a requester raises req with stable sprite/row and keeps them until the
  // cycle its rsp_valid bit pulses; rsp_data is valid exactly in that cycle. Fields are
  // captured at grant time, so later changes (or a dropped req) do not affect the access.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          idx_q;
  logic                   hit_q;
  logic [1:0]             cnt_q;
  logic [SW+RW-1:0]       rom_addr_q;
  logic [TILE_SIZE-1:0]   rsp_data_q;
  logic [N_REQ-1:0]       idx_oh;

  logic                   win_found;
  logic [IW-1:0]          win_idx;
  logic [IW:0]            scan;
  logic [SW-1:0]          sel_sprite;
  logic [RW-1:0]          sel_row;
  logic                   sel_hit;

  // Scan starts at rr_ptr and wraps, so the last winner is checked last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan = {1'b0, rr_ptr} + (IW+1)'(i);
      if (scan >= (IW+1)'(N_REQ)) scan = scan - (IW+1)'(N_REQ);
      if (!win_found && req[scan[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[IW-1:0];
      end
    end
  end

  assign sel_sprite = req_sprite[win_idx*SW +: SW];
  assign sel_row    = req_row[win_idx*RW +: RW];
  assign sel_hit    = (int'(sel_sprite) < N_SPRITES) && (int'(sel_row) < TILE_SIZE);
  assign idx_oh     = N_REQ'(1) << idx_q;

  always_comb begin
    state_d   = state_q;
    gnt       = '0;
    rom_en    = 1'b0;
    rsp_valid = '0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  if (win_found) state_d = S_ISSUE;
      S_ISSUE: begin
        gnt     = idx_oh;
        rom_en  = hit_q;
        state_d = S_WAIT;
      end
      S_WAIT:  if (cnt_q == 2'd0) state_d = S_DONE;
      S_DONE: begin
        rsp_valid = idx_oh;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr     <= '0;
      idx_q      <= '0;
      hit_q      <= 1'b0;
      cnt_q      <= 2'd0;
      rom_addr_q <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (win_found) begin
          idx_q      <= win_idx;
          hit_q      <= sel_hit;
          rom_addr_q <= {sel_sprite, sel_row};
        end
        S_ISSUE: cnt_q <= 2'(ROM_LAT - 1);
        S_WAIT: begin
          if (cnt_q != 2'd0) cnt_q <= cnt_q - 2'd1;
          else rsp_data_q <= hit_q ? rom_data : '0;
        end
        S_DONE: rr_ptr <= (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);
        default: ;
      endcase
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rsp_data  = rsp_data_q;
  assign fsm_state = state_q;

endmodule
